// File: rtl/paddle_hit_if.sv
// Video/ball bundle seen by one paddle. Supplies fallback table, ball and
// direction geometry macros when the shared defs file is not compiled in.
`ifndef TABLE_TOP
`define TABLE_TOP 11'd10
`endif
`ifndef TABLE_BOTTOM
`define TABLE_BOTTOM 11'd470
`endif
`ifndef BALL_HSIZE
`define BALL_HSIZE 11'd8
`endif
`ifndef BALL_VSIZE
`define BALL_VSIZE 11'd8
`endif
`ifndef LEFT
`define LEFT 1'b0
`endif
`ifndef RIGHT
`define RIGHT 1'b1
`endif

interface paddle_hit_if;
   logic [10:0] hcount;
   logic [10:0] vcount;
   logic        vblank;
   logic        btn_up;
   logic        btn_down;
   logic [10:0] ball_h_init;
   logic [10:0] ball_v_init;
   logic        ball_h_dir;
   logic [10:0] paddle_v_init;
   logic        pixel_valid;
   logic        change_dir;
   logic        miss;

   modport master (
      output hcount, vcount, vblank, btn_up, btn_down,
             ball_h_init, ball_v_init, ball_h_dir,
      input  paddle_v_init, pixel_valid, change_dir, miss
   );

   modport slave (
      input  hcount, vcount, vblank, btn_up, btn_down,
             ball_h_init, ball_v_init, ball_h_dir,
      output paddle_v_init, pixel_valid, change_dir, miss
   );
endinterface

// File: rtl/paddle_hit.sv
// One player's paddle: per-frame motion, drawing, ball collision and miss detect.
// Define PADDLE_AI_EN to replace button control with ball-tracking motion.
`ifndef TABLE_TOP
`define TABLE_TOP 11'd10
`endif
`ifndef TABLE_BOTTOM
`define TABLE_BOTTOM 11'd470
`endif
`ifndef BALL_HSIZE
`define BALL_HSIZE 11'd8
`endif
`ifndef BALL_VSIZE
`define BALL_VSIZE 11'd8
`endif
`ifndef LEFT
`define LEFT 1'b0
`endif
`ifndef RIGHT
`define RIGHT 1'b1
`endif

module paddle_hit #(
   parameter logic [10:0] PADDLE_X        = 11'd20,
   parameter logic [10:0] PADDLE_W        = 11'd8,
   parameter logic [10:0] PADDLE_H        = 11'd64,
   parameter logic [10:0] PADDLE_STEP     = 11'd4,
   parameter bit          SIDE_RIGHT      = 1'b0,
   parameter int unsigned COOLDOWN_FRAMES = 8
) (
   input logic         clk,
   input logic         rst_n,
   paddle_hit_if.slave bus
);

   typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, COOL = 2'd2} state_t;

   // 12-bit copies so every bound sum is computed without wrapping
   localparam logic [11:0] X_LO   = {1'b0, PADDLE_X};
   localparam logic [11:0] X_HI   = {1'b0, PADDLE_X} + {1'b0, PADDLE_W};
   localparam logic [11:0] TOP    = {1'b0, `TABLE_TOP};
   localparam logic [11:0] BOT    = {1'b0, `TABLE_BOTTOM};
   localparam logic [11:0] STEP   = {1'b0, PADDLE_STEP};
   localparam logic [11:0] HGT    = {1'b0, PADDLE_H};
   localparam logic [11:0] BHS    = {1'b0, `BALL_HSIZE};
   localparam logic [11:0] BVS    = {1'b0, `BALL_VSIZE};
   localparam logic [10:0] V_MAX  = 11'(`TABLE_BOTTOM - PADDLE_H);
   localparam logic [10:0] V_RST  = 11'((`TABLE_TOP + `TABLE_BOTTOM - PADDLE_H) >> 1);
   localparam logic [7:0]  C_LOAD = 8'(COOLDOWN_FRAMES - 1);

   state_t      state_r, state_s;
   logic [7:0]  cnt_r, cnt_s;
   logic        vblank_d_r, vblank_rise_s;
   logic [10:0] paddle_v_r, paddle_v_s;
   logic        pixel_valid_r, change_dir_r, miss_r;
   logic        move_up_s, move_down_s;
   logic        overlap_s, toward_s, in_paddle_s, miss_s;
   logic [11:0] ball_h_s, ball_v_s, pad_v_s, hc_s, vc_s;

   assign vblank_rise_s = bus.vblank & ~vblank_d_r;
   assign ball_h_s      = {1'b0, bus.ball_h_init};
   assign ball_v_s      = {1'b0, bus.ball_v_init};
   assign pad_v_s       = {1'b0, paddle_v_r};
   assign hc_s          = {1'b0, bus.hcount};
   assign vc_s          = {1'b0, bus.vcount};

   assign toward_s    = SIDE_RIGHT ? (bus.ball_h_dir == `RIGHT) : (bus.ball_h_dir == `LEFT);
   assign overlap_s   = toward_s
                      && (ball_h_s <= X_HI) && (ball_h_s + BHS >= X_LO)
                      && (ball_v_s <= pad_v_s + HGT) && (ball_v_s + BVS >= pad_v_s);
   assign in_paddle_s = (hc_s >= X_LO) && (hc_s <= X_HI)
                      && (vc_s >= pad_v_s) && (vc_s <= pad_v_s + HGT);
   assign miss_s      = vblank_rise_s && (state_r == IDLE) && toward_s
                      && (SIDE_RIGHT ? (ball_h_s > X_HI) : (ball_h_s + BHS < X_LO));

`ifdef PADDLE_AI_EN
   logic [11:0] ball_cy_s, pad_cy_s;
   assign ball_cy_s = ball_v_s + {1'b0, `BALL_VSIZE >> 1};
   assign pad_cy_s  = pad_v_s + {1'b0, PADDLE_H >> 1};

   // Track the ball centre with a dead band of one step
   always_comb begin
      move_up_s   = 1'b0;
      move_down_s = 1'b0;
      if (ball_cy_s + STEP < pad_cy_s) begin
         move_up_s = 1'b1;
      end else if (ball_cy_s > pad_cy_s + STEP) begin
         move_down_s = 1'b1;
      end else begin
         move_up_s   = 1'b0;
         move_down_s = 1'b0;
      end
   end
`else
   // Button control; both buttons together cancel out
   always_comb begin
      move_up_s   = 1'b0;
      move_down_s = 1'b0;
      if (bus.btn_up && !bus.btn_down) begin
         move_up_s = 1'b1;
      end else if (bus.btn_down && !bus.btn_up) begin
         move_down_s = 1'b1;
      end else begin
         move_up_s   = 1'b0;
         move_down_s = 1'b0;
      end
   end
`endif

   // Next paddle position, clamped to the table without wrapping
   always_comb begin
      paddle_v_s = paddle_v_r;
      if (vblank_rise_s && move_up_s) begin
         if (pad_v_s < TOP + STEP) paddle_v_s = `TABLE_TOP;
         else                      paddle_v_s = paddle_v_r - PADDLE_STEP;
      end else if (vblank_rise_s && move_down_s) begin
         if (pad_v_s + STEP + HGT > BOT) paddle_v_s = V_MAX;
         else                            paddle_v_s = paddle_v_r + PADDLE_STEP;
      end else begin
         paddle_v_s = paddle_v_r;
      end
   end

   // Hit FSM: arm only outside vblank so the ball never samples a partial request
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      case (state_r)
         IDLE: begin
            if (overlap_s && !bus.vblank) state_s = ARMED;
            else                          state_s = IDLE;
         end
         ARMED: begin
            if (vblank_rise_s) begin
               state_s = COOL;
               cnt_s   = C_LOAD;
            end else begin
               state_s = ARMED;
            end
         end
         COOL: begin
            if (vblank_rise_s) begin
               if (cnt_r == 8'd0) state_s = IDLE;
               else               cnt_s   = cnt_r - 8'd1;
            end else begin
               state_s = COOL;
            end
         end
         default: begin
            state_s = IDLE;
            cnt_s   = 8'd0;
         end
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= IDLE;
         cnt_r         <= 8'd0;
         vblank_d_r    <= 1'b0;
         paddle_v_r    <= V_RST;
         pixel_valid_r <= 1'b0;
         change_dir_r  <= 1'b0;
         miss_r        <= 1'b0;
      end else begin
         state_r       <= state_s;
         cnt_r         <= cnt_s;
         vblank_d_r    <= bus.vblank;
         paddle_v_r    <= paddle_v_s;
         pixel_valid_r <= in_paddle_s;
         change_dir_r  <= (state_s == ARMED);
         miss_r        <= miss_s;
      end
   end

   assign bus.paddle_v_init = paddle_v_r;
   assign bus.pixel_valid   = pixel_valid_r;
   assign bus.change_dir    = change_dir_r;
   assign bus.miss          = miss_r;

endmodule
